// File: rtl/noob_fixed_arb.sv
// Fixed-priority arbiter (bit 0 highest) with registered grant, saturating grant counters
// and an optional per-requester starvation monitor enabled by NOOB_FIXED_ARB_STARVE_EN.
module noob_fixed_arb #(
    parameter int N         = 3,
    parameter int CNT_W     = 8,
    parameter int STARVE_TH = 16,
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    output logic [N-1:0]       grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [N-1:0]       grant_q,
    output logic [N*CNT_W-1:0] grant_cnt,
    output logic [N-1:0]       starve
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (N < 2 || STARVE_TH < 1 || STARVE_TH > (1 << CNT_W) - 1) begin : g_bad_params
        $error("noob_fixed_arb: need N >= 2 and 1 <= STARVE_TH <= 2**CNT_W-1");
    end

    // Lowest set bit of req: req & -req.
    always_comb begin
        grant       = req & (~req + N'(1));
        grant_valid = |req;
    end

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    logic [N-1:0]            grant_dly_d, grant_dly_q;
    logic [N-1:0][CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        grant_dly_d = grant;
        cnt_d       = cnt_q;
        for (int i = 0; i < N; i++) begin
            if (grant[i] && cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: the counter array is reset element-wise like any other flop; none of
    // these registers may come out of reset as X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_dly_q <= '0;
            cnt_q       <= '0;
        end else begin
            grant_dly_q <= grant_dly_d;
            cnt_q       <= cnt_d;
        end
    end

    assign grant_q   = grant_dly_q;
    assign grant_cnt = cnt_q;

`ifdef NOOB_FIXED_ARB_STARVE_EN
    logic [N-1:0][CNT_W-1:0] starve_cnt_d, starve_cnt_q;
    logic [N-1:0]            starve_d, starve_q;

    // The flag is derived from the next count so it rises on the same edge the
    // count reaches the threshold, and drops on the edge the count clears.
    always_comb begin
        starve_cnt_d = '0;
        starve_d     = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !grant[i]) begin
                starve_cnt_d[i] = (starve_cnt_q[i] == CNT_MAX) ? CNT_MAX
                                                               : starve_cnt_q[i] + CNT_W'(1);
            end
            starve_d[i] = (starve_cnt_d[i] >= CNT_W'(STARVE_TH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            starve_q     <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    assign starve = '0;
`endif

endmodule

// File: tb/tb_noob_fixed_arb.sv
// Self-checking bench for noob_fixed_arb: directed steps plus random requests,
// compared against a priority-search reference model.
module tb_noob_fixed_arb;

    localparam int N         = 3;
    localparam int CNT_W     = 8;
    localparam int STARVE_TH = 16;
    localparam int IDX_W     = 2;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       req;
    logic [N-1:0]       grant;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [N-1:0]       grant_q;
    logic [N*CNT_W-1:0] grant_cnt;
    logic [N-1:0]       starve;

    int checks = 0;
    int errors = 0;

    // Reference state: plain integers.
    int m_gq;
    int m_cnt [N];
    int m_scnt[N];
    int m_starve;

    noob_fixed_arb #(.N(N), .CNT_W(CNT_W), .STARVE_TH(STARVE_TH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .grant_q    (grant_q),
        .grant_cnt  (grant_cnt),
        .starve     (starve)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Highest-priority requester is the first set bit found scanning up from 0.
    function automatic int ref_idx(input int r);
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int ref_grant(input int r);
        int k;
        k = ref_idx(r);
        return (k < 0) ? 0 : (1 << k);
    endfunction

    function automatic longint packed_cnt();
        longint v;
        v = 0;
        for (int i = 0; i < N; i++) v = v | (longint'(m_cnt[i]) << (i * CNT_W));
        return v;
    endfunction

    task automatic model_edge();
        int g, r;
        r = int'(req);
        g = ref_grant(r);
        if (!rst_n) begin
            m_gq = 0; m_starve = 0;
            for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_scnt[i] = 0; end
        end else begin
            m_gq = g;
            m_starve = 0;
            for (int i = 0; i < N; i++) begin
                if (g[i]) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                if (r[i] && !g[i]) m_scnt[i] = (m_scnt[i] < CMAX) ? m_scnt[i] + 1 : CMAX;
                else               m_scnt[i] = 0;
`ifdef NOOB_FIXED_ARB_STARVE_EN
                if (m_scnt[i] >= STARVE_TH) m_starve = m_starve | (1 << i);
`endif
            end
        end
    endtask

    task automatic check_comb(input string tag);
        int r, k;
        r = int'(req);
        k = ref_idx(r);
        check({tag, ".grant"}, grant, ref_grant(r));
        check({tag, ".valid"}, grant_valid, (r != 0));
        check({tag, ".idx"}, grant_idx, (k < 0) ? 0 : k);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".grant_q"}, grant_q, m_gq);
        check({tag, ".grant_cnt"}, grant_cnt, packed_cnt());
        check({tag, ".starve"}, starve, m_starve);
    endtask

    // One cycle: drive after the falling edge, check comb, clock, check registers.
    task automatic step(input logic [N-1:0] v, input string tag);
        @(negedge clk);
        req = v;
        #1 check_comb(tag);
        @(posedge clk);
        model_edge();
        #1 check_regs(tag);
    endtask

    initial begin
        logic [N-1:0] prev_g;
        rst_n = 1'b0;
        req   = '0;

        // Reset: comb outputs still follow req, registers clear.
        step(3'b000, "rst0");
        step(3'b111, "rst1");
        check("rst.cnt_zero", grant_cnt, 0);
        check("rst.gq_zero", grant_q, 0);
        rst_n = 1'b1;

        step(3'b001, "seq001");
        step(3'b011, "seq011");
        step(3'b111, "seq111");
        step(3'b010, "seq010");
        step(3'b000, "idle");

        // Mid-cycle change: grant follows instantly, edge samples the last value.
        @(negedge clk);
        req = 3'b100;
        #1 check_comb("mid_a");
        #2 req = 3'b110;
        #1 check_comb("mid_b");
        @(posedge clk);
        model_edge();
        #1 check_regs("mid");

        // Exhaustive sweep with one-hot/subset and one-cycle-delay properties.
        for (int v = 0; v < (1 << N); v++) begin
            step(N'(v), "sweep");
            check("sweep.onehot0", $onehot0(grant), 1);
            check("sweep.subset", grant & ~req, 0);
        end
        for (int v = 0; v < (1 << N); v++) begin
            @(negedge clk);
            req = N'(v);
            #1 prev_g = grant;
            @(posedge clk);
            model_edge();
            #1 check("sweep.gq_prev", grant_q, prev_g);
        end

        for (int c = 0; c < 200; c++) step(N'($urandom_range((1 << N) - 1)), "rand");

        // Reset mid-operation, then resume counting from zero.
        rst_n = 1'b0;
        step(3'b101, "mid_rst");
        rst_n = 1'b1;
        step(3'b010, "resume");
        check("resume.cnt1", grant_cnt, 1 << CNT_W);

        // Saturation: 300 cycles of req=111 after a fresh reset.
        rst_n = 1'b0;
        step(3'b000, "sat_rst");
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) step(3'b111, "sat");
        check("sat.cnt0", grant_cnt[CNT_W-1:0], 255);
        check("sat.cnt12", grant_cnt[N*CNT_W-1:CNT_W], 0);

        // Starvation: req=011 held, requester 1 loses every cycle.
        rst_n = 1'b0;
        step(3'b000, "stv_rst");
        rst_n = 1'b1;
        for (int c = 0; c < STARVE_TH - 1; c++) step(3'b011, "stv_pre");
        check("stv.before_th", starve, 0);
        step(3'b011, "stv_th");
`ifdef NOOB_FIXED_ARB_STARVE_EN
        check("stv.at_th", starve, 3'b010);
`else
        check("stv.at_th", starve, 3'b000);
`endif
        step(3'b011, "stv_th1");
        step(3'b001, "stv_drop");
        check("stv.cleared", starve, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
